// File: rtl/counters_pkg.sv
// counters_pkg
// Shared declarations for the counters library:
//   clog2    - ceiling log2, used to size internal counters
//   max_val  - largest count value for a given modulus
//   dir_t    - count direction encoding (DIR_DN = 0, DIR_UP = 1)
package counters_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((1 << n) < value) begin
            n = n + 1;
        end
        return n;
    endfunction

    function automatic int max_val(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/updown_counter_mod_en_prescaler.sv
// en_prescaler
// Divides the enable stream: tick is high on every PRESCALE-th enabled cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears the internal count)
//   en   - enable; the internal count only advances while en=1
//   clr  - synchronous clear (used when the parent loads a new value)
//   tick - combinational step strobe
// With PRESCALE=1 no register is built and tick is simply en.
module en_prescaler
    import counters_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_direct
            assign tick = en;

            // Clock, reset and clear have no state to act on here.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr};
        end else begin : g_divider
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_cnt_reg;

            // en=0 freezes the count so a partial window is resumed, not lost.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    pre_cnt_reg <= '0;
                end else if (en) begin
                    if (pre_cnt_reg == LAST) begin
                        pre_cnt_reg <= '0;
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                    end
                end
            end

            assign tick = en && (pre_cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod
// Synchronous up/down counter with programmable modulus, parallel load,
// wrap/saturate boundary mode and an optional enable prescaler.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (count = RESET_VAL)
//   en       - count enable, gates prescaler and stepping
//   up_dn    - 1 = increment, 0 = decrement
//   sat_mode - 1 = saturate at boundary, 0 = wrap
//   load     - synchronous parallel load (ignores en)
//   load_val - value to load, clamped to MODULUS-1
//   count    - registered counter value
//   tc       - combinational terminal count for the current direction
//   wrap_p   - registered one-cycle pulse after a wrap
//   sat_p    - registered one-cycle pulse after a step blocked by saturation
// Edge priority: rst > load > step > hold.
module updown_counter_mod
    import counters_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_p,
    output logic             sat_p
);

    // WIDTH-bit boundary constants keep every comparison inside WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(max_val(MODULUS));
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             sat_reg, sat_next;
    logic             tick;
    logic             at_top, at_bot;
    dir_t             dir;

    // Loading restarts the prescale window so the first step after a load
    // is a full PRESCALE enabled cycles away.
    en_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    assign dir    = dir_t'(up_dn);
    assign at_top = (count_reg == MAX_V);
    assign at_bot = (count_reg == '0);
    assign tc     = (dir == DIR_UP) ? at_top : at_bot;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        sat_next   = 1'b0;
        if (load) begin
            count_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (!at_top) begin
                    count_next = count_reg + 1'b1;
                end else if (sat_mode) begin
                    sat_next = 1'b1;
                end else begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    count_next = count_reg - 1'b1;
                end else if (sat_mode) begin
                    sat_next = 1'b1;
                end else begin
                    count_next = MAX_V;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= RESET_V;
            wrap_reg  <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            sat_reg   <= sat_next;
        end
    end

    assign count  = count_reg;
    assign wrap_p = wrap_reg;
    assign sat_p  = sat_reg;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod. Four instances share clk, rst and
// the direction/mode/load-value inputs; each has its own en and load so only
// the instance under test moves at any time.
//   u8 : MODULUS=8, PRESCALE=1
//   u6 : MODULUS=6, PRESCALE=1
//   u3 : MODULUS=8, PRESCALE=3
//   u4 : MODULUS=8, PRESCALE=4
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up_dn = 1'b1;
    logic       sat_mode = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic       en8 = 1'b0, load8 = 1'b0;
    logic       en6 = 1'b0, load6 = 1'b0;
    logic       en3 = 1'b0, load3 = 1'b0;
    logic       en4 = 1'b0, load4 = 1'b0;

    logic [2:0] count8, count6, count3, count4;
    logic       tc8, tc6, tc3, tc4;
    logic       wrap8, wrap6, wrap3, wrap4;
    logic       sat8, sat6, sat3, sat4;

    int checks_total = 0;
    int checks_pass  = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .RESET_VAL(0)) u8 (
        .clk(clk), .rst(rst), .en(en8), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load8), .load_val(load_val), .count(count8), .tc(tc8),
        .wrap_p(wrap8), .sat_p(sat8));

    updown_counter_mod #(.WIDTH(3), .MODULUS(6), .PRESCALE(1), .RESET_VAL(0)) u6 (
        .clk(clk), .rst(rst), .en(en6), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load6), .load_val(load_val), .count(count6), .tc(tc6),
        .wrap_p(wrap6), .sat_p(sat6));

    updown_counter_mod #(.WIDTH(3), .MODULUS(8), .PRESCALE(3), .RESET_VAL(0)) u3 (
        .clk(clk), .rst(rst), .en(en3), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load3), .load_val(load_val), .count(count3), .tc(tc3),
        .wrap_p(wrap3), .sat_p(sat3));

    updown_counter_mod #(.WIDTH(3), .MODULUS(8), .PRESCALE(4), .RESET_VAL(0)) u4 (
        .clk(clk), .rst(rst), .en(en4), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load4), .load_val(load_val), .count(count4), .tc(tc4),
        .wrap_p(wrap4), .sat_p(sat4));

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            checks_pass++;
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state of all instances ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst u8 count", 32'(count8), 0);
        check("rst u8 wrap",  32'(wrap8),  0);
        check("rst u8 sat",   32'(sat8),   0);
        check("rst u8 tc",    32'(tc8),    0);
        check("rst u6 count", 32'(count6), 0);
        check("rst u6 flags", 32'({wrap6, sat6, tc6}), 0);
        check("rst u3 count", 32'(count3), 0);
        check("rst u3 flags", 32'({wrap3, sat3, tc3}), 0);
        check("rst u4 count", 32'(count4), 0);
        check("rst u4 flags", 32'({wrap4, sat4, tc4}), 0);

        // ---------------- mod-8 wrap up ----------------
        up_dn = 1'b1; sat_mode = 1'b0; en8 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("wrapup count[%0d]", i), 32'(count8), 32'(i % 8));
            check($sformatf("wrapup wrap[%0d]", i), 32'(wrap8), 32'(i == 8));
            check($sformatf("wrapup tc[%0d]", i), 32'(tc8), 32'(i == 7));
        end
        en8 = 1'b0;

        // ---------------- saturate up ----------------
        load8 = 1'b1; load_val = 3'd6;
        step();
        load8 = 1'b0;
        check("sat load", 32'(count8), 6);
        check("sat load pulses", 32'({wrap8, sat8}), 0);
        en8 = 1'b1; sat_mode = 1'b1; up_dn = 1'b1;
        step();
        check("sat s1 count", 32'(count8), 7);
        check("sat s1 sat", 32'(sat8), 0);
        step();
        check("sat s2 count", 32'(count8), 7);
        check("sat s2 sat", 32'(sat8), 1);
        check("sat s2 wrap", 32'(wrap8), 0);
        step();
        check("sat s3 count", 32'(count8), 7);
        check("sat s3 sat", 32'(sat8), 1);
        check("sat s3 wrap", 32'(wrap8), 0);
        en8 = 1'b0;
        step();
        check("sat idle sat", 32'(sat8), 0);

        // ---------------- saturate down, then wrap down ----------------
        load8 = 1'b1; load_val = 3'd0;
        step();
        load8 = 1'b0; up_dn = 1'b0; en8 = 1'b1;
        step();
        check("satdn count", 32'(count8), 0);
        check("satdn sat", 32'(sat8), 1);
        check("satdn tc", 32'(tc8), 1);
        sat_mode = 1'b0;
        step();
        check("wrapdn count", 32'(count8), 7);
        check("wrapdn wrap", 32'(wrap8), 1);
        check("wrapdn sat", 32'(sat8), 0);
        en8 = 1'b0;

        // ---------------- modulus-6 down wrap ----------------
        load6 = 1'b1; load_val = 3'd2; up_dn = 1'b0; sat_mode = 1'b0;
        step();
        load6 = 1'b0;
        check("m6 load", 32'(count6), 2);
        en6 = 1'b1;
        step();
        check("m6 d1", 32'(count6), 1);
        step();
        check("m6 d2", 32'(count6), 0);
        check("m6 tc at 0", 32'(tc6), 1);
        check("m6 no wrap yet", 32'(wrap6), 0);
        step();
        check("m6 d3", 32'(count6), 5);
        check("m6 wrap", 32'(wrap6), 1);
        step();
        check("m6 d4", 32'(count6), 4);
        check("m6 wrap gone", 32'(wrap6), 0);
        en6 = 1'b0;
        up_dn = 1'b1;
        #1;
        check("m6 tc up at 4", 32'(tc6), 0);

        // ---------------- clamp and rst-over-load ----------------
        load6 = 1'b1; load_val = 3'd7;
        step();
        check("m6 clamp 7", 32'(count6), 5);
        check("m6 tc up at 5", 32'(tc6), 1);
        load_val = 3'd6;
        step();
        check("m6 clamp 6", 32'(count6), 5);
        rst = 1'b1; load_val = 3'd3;
        step();
        rst = 1'b0; load6 = 1'b0;
        check("rst beats load", 32'(count6), 0);

        // ---------------- prescaler /3 ----------------
        up_dn = 1'b1; sat_mode = 1'b0; en3 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("ps3 count[%0d]", i), 32'(count3), 32'(i / 3));
        end
        // count=2, window at 0: one enabled edge, two held, then resume
        step();
        check("ps3 gap a", 32'(count3), 2);
        en3 = 1'b0;
        step();
        step();
        check("ps3 gap held", 32'(count3), 2);
        en3 = 1'b1;
        step();
        check("ps3 gap d", 32'(count3), 2);
        step();
        check("ps3 gap e", 32'(count3), 3);
        // advance to the tick cycle, then load on it
        step();
        step();
        check("ps3 pre-load", 32'(count3), 3);
        load3 = 1'b1; load_val = 3'd5;
        step();
        load3 = 1'b0;
        check("ps3 load on tick", 32'(count3), 5);
        step();
        step();
        check("ps3 restart held", 32'(count3), 5);
        step();
        check("ps3 restart step", 32'(count3), 6);
        en3 = 1'b0;

        // ---------------- reset mid-window, prescaler /4 ----------------
        en4 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
        end
        check("ps4 before rst", 32'(count4), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ps4 rst count", 32'(count4), 0);
        step();
        step();
        step();
        check("ps4 after 3", 32'(count4), 0);
        step();
        check("ps4 after 4", 32'(count4), 1);
        en4 = 1'b0;

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
